// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, default sizes and round-robin pick for the GCD scheduler.
package gcd_pkg;
    localparam int GCD_WIDTH = 8;
    localparam int GCD_NREQ  = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RESP = 2'd2} state_t;
    // First set bit of valid at or after ptr, wrapping at n; returns ptr when none is set.
    function automatic int unsigned rr_next(input logic [31:0] valid, input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        rr_next = ptr;
        for (int unsigned k = n; k > 0; k--) begin
            idx = (ptr + k - 1) % n;
            if (valid[idx[4:0]]) rr_next = idx;
        end
    endfunction
endpackage

// File: rtl/gcd_rr_scheduler_core.sv
// gcd_core: iterative subtract-based GCD engine, one step per cycle.
// GCD_TIMEOUT_EN adds an iteration counter that aborts jobs reaching MAX_ITER.
module gcd_core #(
    parameter int WIDTH    = 8,
    parameter int MAX_ITER = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    logic [WIDTH-1:0] x, y;
`ifdef GCD_TIMEOUT_EN
    logic [WIDTH:0] cnt;
    assign err = busy && x != '0 && y != '0 && cnt == (WIDTH+1)'(MAX_ITER);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (start) cnt <= '0;
        else if (busy && !done) cnt <= cnt + 1'b1;
`else
    assign err = 1'b0;
`endif
    assign done   = busy && (x == '0 || y == '0 || err);
    assign result = err ? '0 : (x == '0 ? y : x);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            busy <= 1'b0;
        end else if (start) begin
            x    <= a;
            y    <= b;
            busy <= 1'b1;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            if (x > y) x <= x - y;
            else y <= y - x;
        end
    end
endmodule

// File: rtl/gcd_rr_scheduler.sv
// gcd_rr_scheduler: round-robin sharing of one GCD engine with a tagged response channel.
// Optional abort-on-iteration-limit via GCD_TIMEOUT_EN.
module gcd_rr_scheduler
    import gcd_pkg::*;
#(
    parameter int WIDTH    = GCD_WIDTH,
    parameter int NREQ     = GCD_NREQ,
    parameter int IDW      = 2,
    parameter int MAX_ITER = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_gcd,
    output logic                  rsp_err,
    output logic                  busy
);
    state_t           state;
    logic [IDW-1:0]   ptr, grant;
    logic             xfer, done, core_busy, err;
    logic [WIDTH-1:0] result;
    assign grant     = IDW'(rr_next(32'(req_valid), 32'(ptr), NREQ));
    assign xfer      = state == IDLE && |req_valid;
    assign req_ready = xfer ? NREQ'(1) << grant : '0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE || core_busy;
    gcd_core #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER)) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (xfer),
        .a      (req_a[grant*WIDTH +: WIDTH]),
        .b      (req_b[grant*WIDTH +: WIDTH]),
        .busy   (core_busy),
        .done   (done),
        .result (result),
        .err    (err)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            rsp_id  <= '0;
            rsp_gcd <= '0;
            rsp_err <= 1'b0;
        end else if (xfer) begin
            state  <= RUN;
            rsp_id <= grant;
            ptr    <= grant == IDW'(NREQ - 1) ? '0 : grant + 1'b1;
        end else if (state == RUN && done) begin
            state   <= RESP;
            rsp_gcd <= result;
            rsp_err <= err;
        end else if (state == RESP && rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// tb_gcd_rr_scheduler: directed self-checking bench for the round-robin GCD scheduler.
// Honours GCD_TIMEOUT_EN for the iteration-limit case.
module tb_gcd_rr_scheduler;
    logic        clk = 1'b0, reset;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_gcd;
    int          total = 0, bad = 0;
    gcd_rr_scheduler #(.WIDTH(8), .NREQ(4), .IDW(2), .MAX_ITER(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic job(input int r, input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                       input int lat_exp, input logic err_exp);
        int lat;
        req_a[r*8 +: 8] = a;
        req_b[r*8 +: 8] = b;
        req_valid[r] = 1'b1;
        #1;
        check("grant", 32'(req_ready), 32'(4'b1 << r));
        tick;
        req_valid[r] = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 600) begin
            tick;
            lat++;
        end
        check("rsp_valid", 32'(rsp_valid), 1);
        if (lat_exp >= 0) check("latency", 32'(lat), 32'(lat_exp));
        check("rsp_gcd", 32'(rsp_gcd), 32'(g));
        check("rsp_id", 32'(rsp_id), 32'(r));
        check("rsp_err", 32'(rsp_err), 32'(err_exp));
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 0);
    endtask
    initial begin
        int gnt[5], ids[5], gcds[5];
        int exp_id[5] = '{0, 1, 2, 3, 0};
        int exp_g[5]  = '{6, 2, 3, 1, 6};
        int ng, nr, cyc, n;
        logic [7:0] g6;
        logic       e6;
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        repeat (2) tick;
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_gcd", 32'(rsp_gcd), 0);
        check("rst_err", 32'(rsp_err), 0);
        reset = 1'b0;
        tick;
        job(0, 8'd12, 8'd8, 8'd4, 5, 1'b0);
        job(1, 8'd0, 8'd0, 8'd0, 2, 1'b0);
        job(2, 8'd0, 8'd9, 8'd9, 2, 1'b0);
        job(2, 8'd9, 8'd0, 8'd9, 2, 1'b0);
        job(3, 8'd7, 8'd7, 8'd7, 3, 1'b0);
        // all four contend with the response always accepted
        req_a = {8'd5, 8'd9, 8'd10, 8'd18};
        req_b = {8'd3, 8'd6, 8'd4, 8'd12};
        rsp_ready = 1'b1; req_valid = 4'hf; ng = 0; nr = 0; cyc = 0;
        while (nr < 5 && cyc < 400) begin
            #1;
            if (req_ready != '0 && ng < 5) begin
                check("onehot", 32'($countones(req_ready)), 1);
                for (int k = 0; k < 4; k++) if (req_ready[k]) gnt[ng] = k;
                ng++;
            end
            if (rsp_valid) begin
                ids[nr] = int'(rsp_id);
                gcds[nr] = int'(rsp_gcd);
                nr++;
            end
            tick;
            cyc++;
            if (ng == 5) req_valid = '0;
        end
        rsp_ready = 1'b0;
        check("rr_count", 32'(nr), 5);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant", 32'(gnt[k]), 32'(exp_id[k]));
            check("rr_id", 32'(ids[k]), 32'(exp_id[k]));
            check("rr_gcd", 32'(gcds[k]), 32'(exp_g[k]));
        end
        // backpressure while another requester waits
        req_a[8 +: 8] = 8'd12; req_b[8 +: 8] = 8'd8;
        req_a[16 +: 8] = 8'd10; req_b[16 +: 8] = 8'd4;
        req_valid = 4'b0110;
        #1;
        check("bp_grant", 32'(req_ready), 32'(4'b0010));
        tick;
        req_valid = 4'b0100;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick;
            n++;
        end
        repeat (10) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_gcd", 32'(rsp_gcd), 4);
            check("bp_err", 32'(rsp_err), 0);
            check("bp_ready", 32'(req_ready), 0);
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        check("bp_release", 32'(rsp_valid), 0);
        check("bp_next_grant", 32'(req_ready), 32'(4'b0100));
        tick;
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick;
            n++;
        end
        check("bp2_id", 32'(rsp_id), 2);
        check("bp2_gcd", 32'(rsp_gcd), 2);
        tick;
        rsp_ready = 1'b0;
        // reset in the middle of a long job
        req_a[24 +: 8] = 8'd255; req_b[24 +: 8] = 8'd1; req_valid = 4'b1000;
        #1;
        check("mr_grant", 32'(req_ready), 32'(4'b1000));
        tick;
        req_valid = '0;
        repeat (10) tick;
        check("mr_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("mr_async_busy", 32'(busy), 0);
        check("mr_async_gcd", 32'(rsp_gcd), 0);
        tick;
        check("mr_valid", 32'(rsp_valid), 0);
        check("mr_busy2", 32'(busy), 0);
        check("mr_id", 32'(rsp_id), 0);
        check("mr_gcd", 32'(rsp_gcd), 0);
        check("mr_err", 32'(rsp_err), 0);
        check("mr_ready", 32'(req_ready), 0);
        reset = 1'b0;
        repeat (5) tick;
        check("mr_no_rsp", 32'(rsp_valid), 0);
        check("mr_idle", 32'(busy), 0);
        job(0, 8'd12, 8'd8, 8'd4, 5, 1'b0);
`ifdef GCD_TIMEOUT_EN
        g6 = 8'd0; e6 = 1'b1;
`else
        g6 = 8'd1; e6 = 1'b0;
`endif
        job(1, 8'd255, 8'd1, g6, -1, e6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
